segment_transition: RTL and testbench

SEGMENT_TRANSITION -- requirements
Module: segment_transition

---
 rtl/segment_transition_pkg.sv | 24 ++
 rtl/segment_transition_trigger.sv | 45 ++++
 rtl/segment_transition.sv | 146 ++++++++++++++
 tb/tb_segment_transition.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/segment_transition_pkg.sv
// Shared types for segment playback: transition mode codes and the playback state.
// Pure declarations; no timing or flow-control behaviour.
package segment_transition_pkg;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX  = 8'h00,
    TRANSITION_MODE_SYS_TIME  = 8'h01,
    TRANSITION_MODE_GPIO      = 8'h02,
    TRANSITION_MODE_IMMEDIATE = 8'hFF
  } transition_mode_t;

  typedef enum logic [1:0] {
    PLAY,
    WAIT,
    FINITE,
    HALT
  } seg_state_t;

  function automatic logic mode_is_defined(input logic [7:0] code);
    return (code == TRANSITION_MODE_SYNC_IDX)  || (code == TRANSITION_MODE_SYS_TIME) ||
           (code == TRANSITION_MODE_GPIO)      || (code == TRANSITION_MODE_IMMEDIATE);
  endfunction

endpackage

// File: rtl/segment_transition_trigger.sv
// Evaluates the pending request's wait condition into a single combinational switch pulse.
// Zero latency (only the GPIO history is registered); no backpressure.
module transition_trigger
  import segment_transition_pkg::*;
#(
  parameter int  GPIO_WIDTH = 4,
  localparam int GSEL_W     = (GPIO_WIDTH > 1) ? $clog2(GPIO_WIDTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wait_i,
  input  transition_mode_t      mode_i,
  input  logic [63:0]           value_i,
  input  logic                  step_i,
  input  logic                  idx_last_i,
  input  logic [63:0]           sys_time_i,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic                  switch_o
);

  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [GSEL_W-1:0]     gpio_sel;
  logic                  gpio_rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gpio_q <= '0;
    else         gpio_q <= gpio_i;
  end

  assign gpio_sel  = value_i[GSEL_W-1:0];
  assign gpio_rise = gpio_i[gpio_sel] & ~gpio_q[gpio_sel];

  always_comb begin
    switch_o = 1'b0;
    if (wait_i) begin
      case (mode_i)
        TRANSITION_MODE_SYNC_IDX: switch_o = step_i & idx_last_i;
        TRANSITION_MODE_SYS_TIME: switch_o = (sys_time_i >= value_i);
        TRANSITION_MODE_GPIO:     switch_o = gpio_rise;
        default:                  switch_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/segment_transition.sv
// Sequences sample indices through playback segments and switches segment on a timed/triggered request.
// Switch lands one cycle after its condition; all outputs registered; no backpressure.
module segment_transition
  import segment_transition_pkg::*;
#(
  parameter int  NUM_SEGMENT = 4,
  parameter int  IDX_WIDTH   = 16,
  parameter int  REP_WIDTH   = 16,
  parameter int  GPIO_WIDTH  = 4,
  localparam int SEG_W       = $clog2(NUM_SEGMENT)
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  UPDATE,
  input  logic [SEG_W-1:0]                      REQ_SEGMENT,
  input  logic [7:0]                            TRANSITION_MODE,
  input  logic [63:0]                           TRANSITION_VALUE,
  input  logic [NUM_SEGMENT-1:0][IDX_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENT-1:0][REP_WIDTH-1:0] REP,
  input  logic                                  STEP,
  input  logic [63:0]                           SYS_TIME,
  input  logic [GPIO_WIDTH-1:0]                 GPIO_IN,
  output logic [SEG_W-1:0]                      SEGMENT,
  output logic [IDX_WIDTH-1:0]                  IDX,
  output logic                                  PENDING,
  output logic                                  STOP,
  output logic                                  REQ_ERR
);

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);

  seg_state_t             state_q, state_d;
  logic [SEG_W-1:0]       seg_q, seg_d, tseg_q, tseg_d, new_seg;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d, cycle_len;
  logic [REP_WIDTH-1:0]   loop_q, loop_d;
  logic                   pend_q, pend_d, stop_q, stop_d, err_q, err_d;
  transition_mode_t       mode_q, mode_d;
  logic [63:0]            value_q, value_d;
  logic                   idx_last, req_ok, trig_switch, do_switch;

  assign cycle_len = (CYCLE[seg_q] == '0) ? IDX_ONE : CYCLE[seg_q];
  assign idx_last  = (idx_q >= cycle_len - IDX_ONE);
  assign req_ok    = (int'(REQ_SEGMENT) < NUM_SEGMENT) && mode_is_defined(TRANSITION_MODE);

  transition_trigger #(.GPIO_WIDTH(GPIO_WIDTH)) u_trigger (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .wait_i     (state_q == WAIT),
    .mode_i     (mode_q),
    .value_i    (value_q),
    .step_i     (STEP),
    .idx_last_i (idx_last),
    .sys_time_i (SYS_TIME),
    .gpio_i     (GPIO_IN),
    .switch_o   (trig_switch)
  );

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    idx_d     = idx_q;
    loop_d    = loop_q;
    pend_d    = pend_q;
    stop_d    = stop_q;
    err_d     = 1'b0;
    tseg_d    = tseg_q;
    mode_d    = mode_q;
    value_d   = value_q;
    do_switch = 1'b0;
    new_seg   = tseg_q;

    if (STEP && state_q != HALT) begin
      if (!idx_last) begin
        idx_d = idx_q + IDX_ONE;
      end else if (state_q == FINITE && loop_q == REP[seg_q]) begin
        // Last loop done: freeze on the final sample rather than wrapping.
        state_d = HALT;
        stop_d  = 1'b1;
      end else begin
        idx_d = '0;
        if (state_q == FINITE) loop_d = loop_q + REP_ONE;
      end
    end

    if (UPDATE) begin
      if (!req_ok) begin
        err_d = 1'b1;
      end else if (TRANSITION_MODE == TRANSITION_MODE_IMMEDIATE) begin
        do_switch = 1'b1;
        new_seg   = REQ_SEGMENT;
      end else begin
        state_d = WAIT;
        pend_d  = 1'b1;
        tseg_d  = REQ_SEGMENT;
        mode_d  = transition_mode_t'(TRANSITION_MODE);
        value_d = TRANSITION_VALUE;
      end
    end else if (trig_switch) begin
      do_switch = 1'b1;
    end

    // A switch overrides any step taken in the same cycle.
    if (do_switch) begin
      seg_d   = new_seg;
      idx_d   = '0;
      loop_d  = '0;
      pend_d  = 1'b0;
      stop_d  = 1'b0;
      state_d = (&REP[new_seg]) ? PLAY : FINITE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= PLAY;
      seg_q   <= '0;
      idx_q   <= '0;
      loop_q  <= '0;
      pend_q  <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
      tseg_q  <= '0;
      mode_q  <= TRANSITION_MODE_SYNC_IDX;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      tseg_q  <= tseg_d;
      mode_q  <= mode_d;
      value_q <= value_d;
    end
  end

  assign SEGMENT = seg_q;
  assign IDX     = idx_q;
  assign PENDING = pend_q;
  assign STOP    = stop_q;
  assign REQ_ERR = err_q;

endmodule

// File: tb/tb_segment_transition.sv
// Directed scenarios plus a randomized immediate-switch phase checked against a step-count model.
module tb_segment_transition;
  import segment_transition_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              update, update2;
  logic [1:0]        req_seg, req_seg2;
  logic [7:0]        mode;
  logic [63:0]       value, sys_time;
  logic [3:0][15:0]  cycle, rep;
  logic [2:0][15:0]  cycle2, rep2;
  logic              step;
  logic [3:0]        gpio;
  logic [1:0]        segment, segment2;
  logic [15:0]       idx, idx2;
  logic              pending, stop, req_err, pending2, stop2, req_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  segment_transition dut (
    .CLK(clk), .RST_N(rst_n), .UPDATE(update), .REQ_SEGMENT(req_seg),
    .TRANSITION_MODE(mode), .TRANSITION_VALUE(value), .CYCLE(cycle), .REP(rep),
    .STEP(step), .SYS_TIME(sys_time), .GPIO_IN(gpio), .SEGMENT(segment), .IDX(idx),
    .PENDING(pending), .STOP(stop), .REQ_ERR(req_err)
  );

  // Three-segment instance: lets an out-of-range segment number be driven on a 2-bit port.
  segment_transition #(.NUM_SEGMENT(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .UPDATE(update2), .REQ_SEGMENT(req_seg2),
    .TRANSITION_MODE(mode), .TRANSITION_VALUE(value), .CYCLE(cycle2), .REP(rep2),
    .STEP(step), .SYS_TIME(sys_time), .GPIO_IN(gpio), .SEGMENT(segment2), .IDX(idx2),
    .PENDING(pending2), .STOP(stop2), .REQ_ERR(req_err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cyc_of(input int s);
    return (cycle[s] == 16'd0) ? 1 : int'(cycle[s]);
  endfunction

  initial begin
    int  m_seg, m_n, cyc, lim, exp_idx, r;
    bit  m_inf, exp_stop, exp_err;

    rst_n = 1'b0; update = 1'b0; update2 = 1'b0; req_seg = '0; req_seg2 = '0;
    mode = 8'h00; value = '0; sys_time = '0; step = 1'b0; gpio = '0;
    cycle = {16'd5, 16'd3, 16'd6, 16'd4};
    rep   = {16'hFFFF, 16'd1, 16'hFFFF, 16'hFFFF};
    cycle2 = {16'd2, 16'd2, 16'd2};
    rep2   = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    #12;
    chk("rst_segment", segment, 0); chk("rst_idx", idx, 0); chk("rst_pending", pending, 0);
    chk("rst_stop", stop, 0);       chk("rst_req_err", req_err, 0);
    rst_n = 1'b1;
    tick();

    // Sync-to-index switch requested at IDX=1 of a 4-point segment
    step = 1'b1; tick(); step = 1'b0;
    chk("sync_idx1", idx, 1);
    update = 1'b1; req_seg = 2'd1; mode = 8'h00; tick(); update = 1'b0;
    chk("sync_pending", pending, 1); chk("sync_seg_hold", segment, 0);
    step = 1'b1; tick(); chk("sync_idx2", idx, 2);
    tick(); chk("sync_idx3", idx, 3); chk("sync_still_pending", pending, 1);
    tick(); step = 1'b0;
    chk("sync_seg", segment, 1); chk("sync_idx0", idx, 0); chk("sync_pending_clr", pending, 0);

    // System-time threshold
    for (int t = 990; t <= 1003; t++) begin
      sys_time = 64'(t);
      if (t == 990) begin update = 1'b1; req_seg = 2'd3; mode = 8'h01; value = 64'd1000; end
      tick();
      update = 1'b0;
      chk($sformatf("systime_seg_t%0d", t), segment, (t >= 1000) ? 3 : 1);
      chk($sformatf("systime_pend_t%0d", t), pending, (t < 1000) ? 1 : 0);
    end
    chk("systime_idx", idx, 0);

    // Immediate switch into a finite segment, with a coincident step that must not count
    update = 1'b1; req_seg = 2'd2; mode = 8'hFF; step = 1'b1; tick(); update = 1'b0;
    chk("imm_seg", segment, 2); chk("imm_idx", idx, 0); chk("imm_stop", stop, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("finite_idx_k%0d", k), idx, (k < 6) ? (k % 3) : 2);
      chk($sformatf("finite_stop_k%0d", k), stop, (k >= 6) ? 1 : 0);
    end
    step = 1'b0;

    // Leave HALT with an immediate request
    update = 1'b1; req_seg = 2'd0; mode = 8'hFF; tick(); update = 1'b0;
    chk("halt_exit_seg", segment, 0); chk("halt_exit_stop", stop, 0); chk("halt_exit_idx", idx, 0);

    // GPIO trigger on bit 2; a pulse on bit 1 must be ignored
    update = 1'b1; req_seg = 2'd1; mode = 8'h02; value = 64'd2; tick(); update = 1'b0;
    chk("gpio_pending", pending, 1);
    gpio = 4'b0010; tick(); chk("gpio_bit1_seg", segment, 0); chk("gpio_bit1_pend", pending, 1);
    gpio = 4'b0000; tick(); chk("gpio_low_seg", segment, 0);
    gpio = 4'b0100; tick();
    chk("gpio_bit2_seg", segment, 1); chk("gpio_bit2_pend", pending, 0); chk("gpio_bit2_idx", idx, 0);
    gpio = 4'b0000;

    // Undefined mode code
    update = 1'b1; req_seg = 2'd3; mode = 8'h05; tick(); update = 1'b0;
    chk("badmode_err", req_err, 1); chk("badmode_seg", segment, 1); chk("badmode_pend", pending, 0);
    tick(); chk("badmode_err_pulse", req_err, 0);

    // Out-of-range segment on the three-segment instance, then a legal one
    update2 = 1'b1; req_seg2 = 2'd3; mode = 8'hFF; tick(); update2 = 1'b0;
    chk("range_err", req_err2, 1); chk("range_seg", segment2, 0);
    tick(); chk("range_err_pulse", req_err2, 0);
    update2 = 1'b1; req_seg2 = 2'd2; tick(); update2 = 1'b0;
    chk("range_ok_seg", segment2, 2); chk("range_ok_err", req_err2, 0);

    // Reset asserted mid-WAIT discards the request
    sys_time = 64'd0;
    update = 1'b1; req_seg = 2'd2; mode = 8'h01; value = 64'd500; step = 1'b1; tick();
    update = 1'b0; step = 1'b0;
    chk("midwait_pend", pending, 1); chk("midwait_idx", idx, 1);
    rst_n = 1'b0; #2;
    chk("midrst_seg", segment, 0); chk("midrst_idx", idx, 0); chk("midrst_pend", pending, 0);
    chk("midrst_stop", stop, 0);   chk("midrst_err", req_err, 0);
    tick(); rst_n = 1'b1; sys_time = 64'd600; tick(); tick();
    chk("postrst_seg", segment, 0); chk("postrst_pend", pending, 0);

    // Randomized immediate/invalid requests against a step-count model
    for (int s = 0; s < 4; s++) begin
      cycle[s] = 16'($urandom_range(0, 5));
      r = int'($urandom_range(0, 3));
      rep[s] = (r == 3) ? 16'hFFFF : 16'(r);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    m_seg = 0; m_n = 0; m_inf = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step   = 1'($urandom_range(0, 1));
      r      = int'($urandom_range(0, 15));
      update = (r < 2);
      req_seg = 2'($urandom_range(0, 3));
      mode   = (r == 0) ? 8'hFF : 8'($urandom_range(3, 254));
      exp_err = update && (r != 0);
      cyc = cyc_of(m_seg);
      lim = (int'(rep[m_seg]) + 1) * cyc;
      if (update && r == 0) begin
        m_seg = int'(req_seg); m_n = 0; m_inf = (rep[m_seg] == 16'hFFFF);
      end else if (step && (m_inf || m_n < lim)) begin
        m_n++;
      end
      tick();
      update = 1'b0;
      cyc = cyc_of(m_seg);
      lim = (int'(rep[m_seg]) + 1) * cyc;
      exp_stop = !m_inf && (m_n >= lim);
      exp_idx  = exp_stop ? cyc - 1 : m_n % cyc;
      chk($sformatf("rnd_seg_c%0d", c), segment, 64'(m_seg));
      chk($sformatf("rnd_idx_c%0d", c), idx, 64'(exp_idx));
      chk($sformatf("rnd_stop_c%0d", c), stop, 64'(exp_stop));
      chk($sformatf("rnd_err_c%0d", c), req_err, 64'(exp_err));
      chk($sformatf("rnd_pend_c%0d", c), pending, 0);
    end
    step = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
